// File: rtl/rx_deserializer.sv
// rx_deserializer: UART receive data stage that sits behind the start-bit detector.
// After a de_strtbit pulse it samples each bit at mid-bit on the oversample clock.
// It collects DATA_BITS data bits LSB-first, then an optional parity bit, then the stop bit.
// At the stop-bit sample it presents the word with a one-cycle rx_valid strobe and the error flags.
//
// Ports:
//   clk         oversample clock, OVERSAMPLE cycles per bit
//   rst_n       asynchronous active-low reset
//   rx_datain   serial line, the same signal the detector samples (no synchroniser)
//   de_strtbit  1-cycle pulse from the detector when the start bit has ended
//   rx_data     received word, LSB = first data bit on the line
//   rx_valid    1-cycle strobe: rx_data and the flags have just been updated
//   parity_err  parity mismatch of the last frame (always 0 when PARITY_EN=0)
//   frame_err   stop bit of the last frame was sampled low
//   rx_busy     high from frame accept until the stop-bit sample
module rx_deserializer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_datain,
  input  logic                 de_strtbit,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  // Sampling on the edge where tick_q holds OVERSAMPLE/2-1 places the first sample
  // OVERSAMPLE/2 edges after the accept edge, then one sample every OVERSAMPLE edges.
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic              PAR_EN    = (PARITY_EN != 0);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t               state_q, state_n;
  logic [TICK_W-1:0]    tick_q, tick_n, tick_inc;
  logic [BIT_W-1:0]     bit_q, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 par_q, par_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n, perr_n, ferr_n, busy_n;
  logic                 sample;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      state_q    <= state_n;
      tick_q     <= tick_n;
      bit_q      <= bit_n;
      shift_q    <= shift_n;
      par_q      <= par_n;
      rx_data    <= data_n;
      rx_valid   <= valid_n;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
      rx_busy    <= busy_n;
    end
  end

  assign sample   = (tick_q == TICK_MID);
  assign tick_inc = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_n = state_q;
    tick_n  = tick_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    par_n   = par_q;
    data_n  = rx_data;
    valid_n = 1'b0;
    perr_n  = parity_err;
    ferr_n  = frame_err;
    busy_n  = rx_busy;

    case (state_q)
      IDLE: begin
        // Start pulses are only accepted here, so frames in flight are never restarted
        if (de_strtbit) begin
          state_n = DATA;
          tick_n  = '0;
          bit_n   = '0;
          par_n   = 1'b0;
          busy_n  = 1'b1;
        end
      end
      DATA: begin
        tick_n = tick_inc;
        if (sample) begin
          // Shift right and insert at the MSB; the word ends up right-aligned, LSB first
          shift_n = {rx_datain, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_n   = '0;
            state_n = PAR_EN ? PARITY : STOP;
          end else begin
            bit_n = bit_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        tick_n = tick_inc;
        if (sample) begin
          par_n   = rx_datain ^ (^shift_q) ^ PAR_ODD;
          state_n = STOP;
        end
      end
      STOP: begin
        tick_n = tick_inc;
        // Finish mid-stop-bit so the detector's next start pulse is accepted immediately
        if (sample) begin
          data_n  = shift_q;
          valid_n = 1'b1;
          ferr_n  = ~rx_datain;
          perr_n  = PAR_EN & par_q;
          busy_n  = 1'b0;
          tick_n  = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rx_deserializer.sv
// tb_rx_deserializer: self-checking bench for rx_deserializer.
// dut0 uses the 8N1 defaults and dut1 uses 8-bit data with even parity.
// Frames are driven from a vector table plus hand-written corner sequences.
// A scoreboard queue per DUT holds each expected word, its flags and the cycle of its rx_valid strobe.
module tb_rx_deserializer;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line0 = 1'b1, de0 = 1'b0, line1 = 1'b1, de1 = 1'b0;
  logic [7:0] data0, data1;
  logic       valid0, valid1, perr0, perr1, ferr0, ferr1, busy0, busy1;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } exp_t;

  typedef struct {
    logic       sel;
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0_ent, e1_ent;

  rx_deserializer dut0 (
    .clk(clk), .rst_n(rst_n), .rx_datain(line0), .de_strtbit(de0),
    .rx_data(data0), .rx_valid(valid0), .parity_err(perr0),
    .frame_err(ferr0), .rx_busy(busy0)
  );

  rx_deserializer #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_datain(line1), .de_strtbit(de1),
    .rx_data(data1), .rx_valid(valid1), .parity_err(perr1),
    .frame_err(ferr1), .rx_busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic set_drv(input logic sel, input logic ln, input logic de);
    if (sel) begin line1 = ln; de1 = de; end
    else begin line0 = ln; de0 = de; end
  endtask

  // Scoreboard: compare every rx_valid strobe with the oldest expected entry
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid0) begin
        if (q0.size() == 0) check("spurious_valid0", 1, 0);
        else begin
          e0_ent = q0.pop_front();
          check("data0", 32'(data0), 32'(e0_ent.data));
          check("perr0", 32'(perr0), 32'(e0_ent.perr));
          check("ferr0", 32'(ferr0), 32'(e0_ent.ferr));
          check("valid_cycle0", 32'(cyc), 32'(e0_ent.cyc));
          check("busy_at_valid0", 32'(busy0), 0);
        end
      end
      if (valid1) begin
        if (q1.size() == 0) check("spurious_valid1", 1, 0);
        else begin
          e1_ent = q1.pop_front();
          check("data1", 32'(data1), 32'(e1_ent.data));
          check("perr1", 32'(perr1), 32'(e1_ent.perr));
          check("ferr1", 32'(ferr1), 32'(e1_ent.ferr));
          check("valid_cycle1", 32'(cyc), 32'(e1_ent.cyc));
          check("busy_at_valid1", 32'(busy1), 0);
        end
      end
    end
  end

  // Drive one frame: start bit, then the detector pulse at E0, data/parity/stop bits.
  // extra_at/rst_at (offsets from E0, -1 = unused) inject a stray start pulse or a reset.
  task automatic send(input logic sel, input logic [7:0] data, input logic par_bit,
                      input logic stop_bit, input logic [7:0] exp_data,
                      input logic exp_perr, input logic exp_ferr,
                      input int extra_at, input int rst_at);
    int nb;
    int e0;
    logic [9:0] bits;
    exp_t ent;
    nb = sel ? 9 : 8;
    bits = {stop_bit, (sel ? par_bit : stop_bit), data};
    repeat (OS) begin
      @(posedge clk); #1;
      set_drv(sel, 1'b0, 1'b0);
    end
    for (int k = 0; k < (nb + 1) * OS; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        e0 = cyc + 1;
        if (rst_at < 0) begin
          ent.data = exp_data; ent.perr = exp_perr; ent.ferr = exp_ferr;
          ent.cyc  = e0 + OS / 2 + nb * OS;
          if (sel) q1.push_back(ent); else q0.push_back(ent);
        end
      end
      set_drv(sel, bits[k / OS], (k == 0) || (k == extra_at));
      if (k == 20) check("busy_mid_frame", 32'(sel ? busy1 : busy0), 1);
      if (k == rst_at) begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(sel ? busy1 : busy0), 0);
        check("rst_valid", 32'(sel ? valid1 : valid0), 0);
        check("rst_data", 32'(sel ? data1 : data0), 0);
        rst_n = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    set_drv(sel, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("pending", 32'(sel ? q1.size() : q0.size()), 0);
    check("busy_after", 32'(sel ? busy1 : busy0), 0);
    if (rst_at < 0) begin
      check("hold_data", 32'(sel ? data1 : data0), 32'(exp_data));
      check("hold_ferr", 32'(sel ? ferr1 : ferr0), 32'(exp_ferr));
    end
  endtask

  vec_t vecs[9];
  logic bad;

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_data", 32'(data0), 0);
    check("reset_valid", 32'(valid0), 0);
    check("reset_perr", 32'(perr0), 0);
    check("reset_ferr", 32'(ferr0), 0);
    check("reset_busy", 32'(busy0), 0);
    rst_n = 1'b1;

    // Idle line with no start pulses: nothing may move
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (valid0 || busy0 || perr0 || ferr0 || (data0 != 8'h00) ||
          valid1 || busy1 || perr1 || ferr1 || (data1 != 8'h00)) bad = 1'b1;
    end
    check("idle_quiet", 32'(bad), 0);

    for (int i = 0; i < 9; i++)
      send(vecs[i].sel, vecs[i].data, vecs[i].par_bit, vecs[i].stop_bit,
           vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr, -1, -1);

    // Stray start pulse mid-frame must not restart or duplicate the frame
    send(1'b0, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 40, -1);

    // Reset mid-frame discards the partial word, then a clean frame follows
    send(1'b0, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, -1, 60);
    send(1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, -1, -1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
